param_register_file: RTL and testbench
======================================

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers, power of two, 2..256.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports, 1..4.
REQ-004 SHALL derive AW = clog2(DEPTH) for all address ports.
REQ-005 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port clr_req  input  1  pulse; starts a soft clear sweep.
REQ-008 SHALL have port we  input  1  write enable.
REQ-009 SHALL have port waddr  input  AW  write address.
REQ-010 SHALL have port wdata  input  DATA_W  write data.
REQ-011 SHALL have port raddr  input  NUM_RD*AW  packed read addresses; port i at bits [i*AW +: AW].
REQ-012 SHALL have port rdata  output  NUM_RD*DATA_W  packed read data; port i at bits [i*DATA_W +: DATA_W].
REQ-013 SHALL have port ready  output  1  high when in RUN state and accepting writes.
REQ-014 SHALL have port wr_drop  output  1  registered pulse: a write with we=1 was discarded on the previous cycle.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR, RUN.
REQ-016 In CLEAR, SHALL zero register clr_idx each cycle, clr_idx counting 0..DEPTH-1, then enter RUN on the cycle after zeroing DEPTH-1.
REQ-017 A CLEAR sweep SHALL take exactly DEPTH cycles; ready SHALL be 0 throughout and 1 from the first RUN cycle.
REQ-018 In RUN, clr_req=1 SHALL enter CLEAR with clr_idx=0 on the next cycle; a write in that same cycle SHALL be discarded.
REQ-019 clr_req during CLEAR SHALL be ignored (sweep not restarted).
REQ-020 In RUN, we=1 with waddr!=0 SHALL write wdata to registers[waddr] at the rising edge.
REQ-021 Register 0 SHALL always read 0; writes to address 0 SHALL be ignored silently (no wr_drop).
REQ-022 Any we=1 cycle in CLEAR, or coinciding with clr_req in RUN, SHALL set wr_drop=1 the following cycle; otherwise wr_drop=0.
REQ-023 Reads SHALL be combinational: rdata[i] = registers[raddr[i]], zero-latency, all ports independent.
REQ-024 In CLEAR, all rdata ports SHALL return 0 regardless of address.
REQ-025 Multiple read ports addressing the same register SHALL return identical data.

Reset
REQ-026 reset=1 at a rising edge SHALL force state=CLEAR, clr_idx=0, wr_drop=0, ready=0, and a full DEPTH-cycle sweep after reset deasserts.
REQ-027 reset asserted mid-sweep or mid-RUN SHALL restart the sweep from index 0; reset SHALL override clr_req and we.
REQ-028 Register contents SHALL NOT be reset in a single cycle; zeroing occurs only via the sweep.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-030 With REGFILE_BYPASS_EN defined, in RUN any read port whose raddr equals waddr while we=1 and waddr!=0 and clr_req=0 SHALL return wdata in that same cycle.
REQ-031 Without REGFILE_BYPASS_EN, such a read SHALL return the old stored value; new data visible from the next cycle.

Verification
REQ-032 Reset 1 cycle, DEPTH=32 -> ready=0 for 32 cycles after reset release, ready=1 on the 33rd; all reads return 0.
REQ-033 In RUN, write 0xDEADBEEF to r5, next cycle raddr port0=5, port1=5 -> both return 0xDEADBEEF.
REQ-034 Write 0x12345678 to r0 -> reading r0 returns 0, wr_drop=0.
REQ-035 Same-cycle write 0xA5A5A5A5 to r7 and read r7 (previously 0x1) -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, 0x1 without.
REQ-036 clr_req with simultaneous we to r3 -> r3 unchanged-then-zeroed, wr_drop=1 next cycle, ready low 32 cycles, r3 reads 0 after.
REQ-037 Assert reset at sweep index 10 -> sweep restarts from 0; ready rises exactly 32 cycles after reset release.

Source files
------------

// File: rtl/param_register_file.sv
`default_nettype none
// =============================================================================
// Module   : param_register_file
// Purpose  : Multi-read-port register file with a sweep-based soft clear.
//            r0 is hardwired to zero. Define REGFILE_BYPASS_EN for same-cycle
//            write-to-read forwarding.
// Revision : 1.0
// =============================================================================
module param_register_file #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_req,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     ready,
  output logic                     wr_drop
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       clr_idx_q, clr_idx_d;
  logic                wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];

  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                run;
  logic                fwd_en;

  assign run = (state_q == ST_RUN);

  // The sweep and normal writes share one storage write port.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wr_drop_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (reset) begin
      state_d   = ST_CLEAR;
      clr_idx_d = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          mem_we    = 1'b1;
          mem_waddr = clr_idx_q;
          mem_wdata = '0;
          wr_drop_d = we;
          if (clr_idx_q == AW'(DEPTH - 1)) begin
            state_d   = ST_RUN;
            clr_idx_d = '0;
          end else begin
            clr_idx_d = clr_idx_q + AW'(1);
          end
        end
        ST_RUN: begin
          if (clr_req) begin
            state_d   = ST_CLEAR;
            clr_idx_d = '0;
            wr_drop_d = we;
          end else if (we && (waddr != '0)) begin
            mem_we = 1'b1;
          end
        end
        default: begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_idx_q <= clr_idx_d;
    wr_drop_q <= wr_drop_d;
  end

  // Storage is deliberately not reset; zeroing happens only through the sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      regs_q[mem_waddr] <= mem_wdata;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign fwd_en = run && we && !clr_req && (waddr != '0);
`else
  assign fwd_en = 1'b0;
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rd_val;
    assign ra     = raddr[i*AW +: AW];
    assign rd_val = (!run || (ra == '0))   ? '0    :
                    (fwd_en && (ra == waddr)) ? wdata :
                    regs_q[ra];
    assign rdata[i*DATA_W +: DATA_W] = rd_val;
  end

  assign ready   = run;
  assign wr_drop = wr_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_param_register_file.sv
`default_nettype none
// =============================================================================
// Module   : tb_param_register_file
// Purpose  : Randomized and directed self-checking bench for param_register_file
//            against a behavioural register-file model.
// Revision : 1.0
// =============================================================================
module tb_param_register_file;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     clr_req;
  logic                     we;
  logic [AW-1:0]            waddr;
  logic [DATA_W-1:0]        wdata;
  logic [NUM_RD*AW-1:0]     raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     ready;
  logic                     wr_drop;

  int errors = 0;
  int checks = 0;

  // Behavioural model: contents, whether we are running, sweep position.
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_run;
  int                m_sweep;
  bit                m_drop;

  param_register_file #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD)
  ) dut (
    .clk(clk), .reset(reset), .clr_req(clr_req), .we(we),
    .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata),
    .ready(ready), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] exp_rd(input int p);
    logic [AW-1:0] a;
    a = raddr[p*AW +: AW];
    if (!m_run || a == '0) return '0;
    if (BYP && we && !clr_req && waddr != '0 && a == waddr) return wdata;
    return m_mem[a];
  endfunction

  // Advance one clock and apply the register-file rules to the model.
  task automatic tick();
    @(posedge clk);
    m_drop = !reset && we && (!m_run || clr_req);
    if (reset) begin
      m_run   = 1'b0;
      m_sweep = 0;
    end else if (!m_run) begin
      m_mem[m_sweep] = '0;
      if (m_sweep == DEPTH - 1) m_run = 1'b1;
      else m_sweep++;
    end else if (clr_req) begin
      m_run   = 1'b0;
      m_sweep = 0;
    end else if (we && waddr != '0) begin
      m_mem[waddr] = wdata;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clr_req = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k <= DEPTH; k++) begin
      raddr = (NUM_RD*AW)'($urandom);
      #1;
      checks++;
      if (ready !== (k == DEPTH)) begin
        errors++;
        $display("FAIL reset_ready k=%0d: got %b expected %b", k, ready, (k == DEPTH));
      end
      if (k < DEPTH) begin
        for (int p = 0; p < NUM_RD; p++) begin
          checks++;
          if (rdata[p*DATA_W +: DATA_W] !== '0) begin
            errors++;
            $display("FAIL reset_read p%0d k=%0d: got %h expected 0", p, k, rdata[p*DATA_W +: DATA_W]);
          end
        end
      end
      if (k == 0) begin
        checks++;
        if (wr_drop !== 1'b0) begin
          errors++;
          $display("FAIL reset_wr_drop: got %b expected 0", wr_drop);
        end
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    idle_inputs();
    raddr = {5'd5, 5'd5};
    #1;
    for (int p = 0; p < NUM_RD; p++) begin
      checks++;
      if (rdata[p*DATA_W +: DATA_W] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL r5_read p%0d: got %h expected deadbeef", p, rdata[p*DATA_W +: DATA_W]);
      end
    end
    tick();
  endtask

  task automatic test_r0();
    idle_inputs();
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
    tick();
    idle_inputs();
    raddr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rdata[DATA_W-1:0] !== '0) begin
      errors++;
      $display("FAIL r0_read: got %h expected 0", rdata[DATA_W-1:0]);
    end
    checks++;
    if (wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL r0_wr_drop: got %b expected 0", wr_drop);
    end
    tick();
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] want;
    idle_inputs();
    we = 1'b1; waddr = 5'd7; wdata = 32'h1;
    tick();
    wdata = 32'hA5A5A5A5;
    raddr = {5'd7, 5'd7};
    #1;
    want = BYP ? 32'hA5A5A5A5 : 32'h1;
    for (int p = 0; p < NUM_RD; p++) begin
      checks++;
      if (rdata[p*DATA_W +: DATA_W] !== want) begin
        errors++;
        $display("FAIL same_cycle_r7 p%0d: got %h expected %h", p, rdata[p*DATA_W +: DATA_W], want);
      end
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rdata[DATA_W-1:0] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL next_cycle_r7: got %h expected a5a5a5a5", rdata[DATA_W-1:0]);
    end
    tick();
  endtask

  task automatic test_clr_write();
    idle_inputs();
    we = 1'b1; waddr = 5'd3; wdata = 32'hCAFE0003;
    tick();
    clr_req = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h11111111;
    raddr = {5'd0, 5'd3};
    #1;
    checks++;
    if (rdata[DATA_W-1:0] !== 32'hCAFE0003) begin
      errors++;
      $display("FAIL clr_cycle_r3: got %h expected cafe0003", rdata[DATA_W-1:0]);
    end
    tick();
    idle_inputs();
    for (int k = 0; k <= DEPTH; k++) begin
      // A second clear request mid-sweep must not restart it.
      clr_req = (k == 5);
      we      = (k == 5);
      #1;
      checks++;
      if (ready !== (k == DEPTH)) begin
        errors++;
        $display("FAIL clr_ready k=%0d: got %b expected %b", k, ready, (k == DEPTH));
      end
      if (k == 0 || k == 1 || k == 6) begin
        checks++;
        if (wr_drop !== (k != 1)) begin
          errors++;
          $display("FAIL clr_wr_drop k=%0d: got %b expected %b", k, wr_drop, (k != 1));
        end
      end
      if (k == DEPTH) begin
        checks++;
        if (rdata[DATA_W-1:0] !== '0) begin
          errors++;
          $display("FAIL clr_r3_after: got %h expected 0", rdata[DATA_W-1:0]);
        end
      end
      tick();
      clr_req = 1'b0; we = 1'b0;
    end
  endtask

  task automatic test_reset_mid_sweep();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    reset = 1'b1;
    clr_req = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'hFFFF0000;
    tick();
    reset = 1'b0;
    idle_inputs();
    for (int k = 0; k <= DEPTH; k++) begin
      #1;
      checks++;
      if (ready !== (k == DEPTH)) begin
        errors++;
        $display("FAIL midsweep_ready k=%0d: got %b expected %b", k, ready, (k == DEPTH));
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      clr_req = ($urandom_range(0, 59) == 0);
      we      = ($urandom_range(0, 2) != 0);
      waddr   = AW'($urandom_range(0, DEPTH - 1));
      wdata   = $urandom;
      raddr   = (NUM_RD*AW)'($urandom);
      if ($urandom_range(0, 3) == 0) raddr[AW-1:0] = waddr;
      #1;
      for (int p = 0; p < NUM_RD; p++) begin
        checks++;
        if (rdata[p*DATA_W +: DATA_W] !== exp_rd(p)) begin
          errors++;
          $display("FAIL rand_read n=%0d p%0d: got %h expected %h", n, p, rdata[p*DATA_W +: DATA_W], exp_rd(p));
        end
      end
      checks++;
      if (ready !== m_run || wr_drop !== m_drop) begin
        errors++;
        $display("FAIL rand_status n=%0d: got ready=%b wr_drop=%b expected ready=%b wr_drop=%b",
                 n, ready, wr_drop, m_run, m_drop);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_run = 1'b0; m_sweep = 0; m_drop = 1'b0;
    reset = 1'b1;
    raddr = '0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_clr_write();
    test_reset_mid_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
